// File: rtl/laser_safety_pkg.sv
// laser_safety_pkg
// Shared definitions for the laser power monitoring path: the FSM state
// encoding, the default sample width and averaging window, and the bit
// positions used inside the packed fault vector.
package laser_safety_pkg;

    localparam int DATA_W_DEFAULT   = 16;
    localparam int AVG_LOG2_DEFAULT = 3;

    // Monitor FSM states; the encoding is fixed so the state can be read
    // back by software debug tools.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } mon_state_t;

    // Bit positions inside the internal fault vector.
    localparam int FAULT_OVER_BIT  = 0;
    localparam int FAULT_UNDER_BIT = 1;
    localparam int FAULT_BITS      = 2;

endpackage

// File: rtl/power_window_avg.sv
// power_window_avg
// Moving average over the last 2^AVG_LOG2 accepted samples. A circular
// buffer holds the window and a running sum is updated by adding the new
// sample and subtracting the one it overwrites.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   clear         synchronous clear of window, pointer, sum and avg_valid
//   push          accept sample_value into the window this cycle
//   sample_value  sample to accept
//   last_slot     the next push fills the final slot of the window
//   avg_value     window sum >> AVG_LOG2 (truncating), registered
//   avg_valid     window has been completely filled since the last clear
module power_window_avg #(
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] sample_value,
    output logic              last_slot,
    output logic [DATA_W-1:0] avg_value,
    output logic              avg_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;

    logic [DATA_W-1:0]   window [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [SUM_W-1:0]    sum;

    // The buffer is zeroed on clear, so while the window fills the
    // subtracted "oldest" entry is zero and the sum simply accumulates.
    // The sum holds at most DEPTH full-scale samples, so SUM_W never overflows.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                window[i] <= '0;
            end
            wr_ptr    <= '0;
            sum       <= '0;
            avg_valid <= 1'b0;
        end else if (push) begin
            window[wr_ptr] <= sample_value;
            wr_ptr         <= wr_ptr + 1'b1;
            sum            <= sum + SUM_W'(sample_value) - SUM_W'(window[wr_ptr]);
            if (last_slot) begin
                avg_valid <= 1'b1;
            end
        end
    end

    assign last_slot = (wr_ptr == {AVG_LOG2{1'b1}});
    assign avg_value = sum[SUM_W-1:AVG_LOG2];

endmodule

// File: rtl/laser_power_monitor.sv
// laser_power_monitor
// Watches the ADC sample stream of a pulsed laser: tracks peak power and an
// 8-sample moving average, debounces over/under-power violations, latches
// faults and drops laser_enable, which gates the laser driver.
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   sample_valid/sample_value one-cycle strobe with the ADC sample
//   monitor_en                level enable for the monitor FSM
//   thr_high/thr_low          over-/under-power limits (strict compares)
//   clear_peak, clear_fault   single-cycle software pulses
//   peak_value                maximum sample since the last clear_peak
//   avg_value, avg_valid      moving average and window-full indication
//   fault_over, fault_under   latched faults
//   laser_enable              high in FILL and RUN only
module laser_power_monitor
    import laser_safety_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int AVG_LOG2   = AVG_LOG2_DEFAULT,
    parameter int TRIP_COUNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_value,
    input  logic              monitor_en,
    input  logic [DATA_W-1:0] thr_high,
    input  logic [DATA_W-1:0] thr_low,
    input  logic              clear_peak,
    input  logic              clear_fault,
    output logic [DATA_W-1:0] peak_value,
    output logic [DATA_W-1:0] avg_value,
    output logic              avg_valid,
    output logic              fault_over,
    output logic              fault_under,
    output logic              laser_enable
);

    // Debounce counters only need to reach TRIP_COUNT, which is at most 15.
    localparam int CNT_W = 4;

    mon_state_t            state, state_next;
    logic [CNT_W-1:0]      over_cnt, under_cnt, over_cnt_next, under_cnt_next;
    logic [FAULT_BITS-1:0] fault, fault_next;
    logic                  laser_enable_next;
    logic                  over_hit, under_hit, trip_over, trip_under;
    logic                  last_slot;

    assign over_hit   = sample_value > thr_high;
    assign under_hit  = sample_value < thr_low;
    assign trip_over  = over_hit  && (over_cnt  == CNT_W'(TRIP_COUNT - 1));
    assign trip_under = under_hit && (under_cnt == CNT_W'(TRIP_COUNT - 1));

    // The window is held cleared for as long as the FSM sits in IDLE, so
    // every FILL starts from an empty window; samples are accepted in every
    // other state, including FAULT.
    power_window_avg #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_window (
        .clk          (clk),
        .rst          (rst),
        .clear        (state == IDLE),
        .push         (sample_valid && (state != IDLE)),
        .sample_value (sample_value),
        .last_slot    (last_slot),
        .avg_value    (avg_value),
        .avg_valid    (avg_valid)
    );

    // State, debounce counters, fault latches and laser_enable are all
    // registered from their next-cycle values so that a trip drops the
    // laser on the same edge that latches the fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            over_cnt     <= '0;
            under_cnt    <= '0;
            fault        <= '0;
            laser_enable <= 1'b0;
        end else begin
            state        <= state_next;
            over_cnt     <= over_cnt_next;
            under_cnt    <= under_cnt_next;
            fault        <= fault_next;
            laser_enable <= laser_enable_next;
        end
    end

    // Next-state logic. Dropping monitor_en aborts FILL/RUN but is ignored
    // in FAULT so a latched fault can only be released by clear_fault, and
    // only when the sample arriving in the same cycle is not itself bad.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (monitor_en) state_next = FILL;
            end
            FILL: begin
                if (!monitor_en)                    state_next = IDLE;
                else if (sample_valid && last_slot) state_next = RUN;
            end
            RUN: begin
                if (!monitor_en)                                       state_next = IDLE;
                else if (sample_valid && (trip_over || trip_under))    state_next = FAULT;
            end
            FAULT: begin
                if (clear_fault && !(sample_valid && (over_hit || under_hit)))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath decode: debounce counting happens only on samples
    // checked in RUN; leaving FAULT or sitting in IDLE wipes counters and
    // flags. Both flags can set on the same sample.
    always_comb begin
        over_cnt_next     = over_cnt;
        under_cnt_next    = under_cnt;
        fault_next        = fault;
        laser_enable_next = (state_next == FILL) || (state_next == RUN);
        case (state)
            IDLE: begin
                over_cnt_next  = '0;
                under_cnt_next = '0;
                fault_next     = '0;
            end
            RUN: begin
                if (monitor_en && sample_valid) begin
                    over_cnt_next  = over_hit  ? over_cnt  + 1'b1 : '0;
                    under_cnt_next = under_hit ? under_cnt + 1'b1 : '0;
                    if (trip_over)  fault_next[FAULT_OVER_BIT]  = 1'b1;
                    if (trip_under) fault_next[FAULT_UNDER_BIT] = 1'b1;
                end
            end
            FAULT: begin
                if (state_next == IDLE) begin
                    over_cnt_next  = '0;
                    under_cnt_next = '0;
                    fault_next     = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Peak tracker runs regardless of FSM state. A clear coincident with a
    // sample restarts tracking from that sample rather than from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_value <= '0;
        end else if (clear_peak) begin
            peak_value <= sample_valid ? sample_value : '0;
        end else if (sample_valid && (sample_value > peak_value)) begin
            peak_value <= sample_value;
        end
    end

    assign fault_over  = fault[FAULT_OVER_BIT];
    assign fault_under = fault[FAULT_UNDER_BIT];

endmodule

// File: tb/tb_laser_power_monitor.sv
// tb_laser_power_monitor
// Directed bench for laser_power_monitor: reset values, window fill and
// averaging, over/under-power debounce and trip, fault clear rules, peak
// tracking and reset in the middle of a fill.
module tb_laser_power_monitor;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sample_value;
    logic        monitor_en;
    logic [15:0] thr_high;
    logic [15:0] thr_low;
    logic        clear_peak;
    logic        clear_fault;
    logic [15:0] peak_value;
    logic [15:0] avg_value;
    logic        avg_valid;
    logic        fault_over;
    logic        fault_under;
    logic        laser_enable;

    int total = 0;
    int bad   = 0;

    laser_power_monitor #(
        .DATA_W     (16),
        .AVG_LOG2   (3),
        .TRIP_COUNT (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_value (sample_value),
        .monitor_en   (monitor_en),
        .thr_high     (thr_high),
        .thr_low      (thr_low),
        .clear_peak   (clear_peak),
        .clear_fault  (clear_fault),
        .peak_value   (peak_value),
        .avg_value    (avg_value),
        .avg_valid    (avg_valid),
        .fault_over   (fault_over),
        .fault_under  (fault_under),
        .laser_enable (laser_enable)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle sample strobe; on return the outputs reflect that sample.
    task automatic applyStimulus(input logic [15:0] value);
        sample_valid = 1'b1;
        sample_value = value;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_peak"},   32'(peak_value),   32'h0);
        checkOutput({tag, "_avg"},    32'(avg_value),    32'h0);
        checkOutput({tag, "_avgv"},   32'(avg_valid),    32'h0);
        checkOutput({tag, "_fover"},  32'(fault_over),   32'h0);
        checkOutput({tag, "_funder"}, 32'(fault_under),  32'h0);
        checkOutput({tag, "_len"},    32'(laser_enable), 32'h0);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_value = '0;
        monitor_en   = 1'b0;
        thr_high     = 16'h0800;
        thr_low      = 16'h0040;
        clear_peak   = 1'b0;
        clear_fault  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkReset("reset");

        // Enter FILL: laser enabled, window not yet valid.
        monitor_en = 1'b1;
        tick();
        checkOutput("fill_len", 32'(laser_enable), 32'h1);
        checkOutput("fill_avgv", 32'(avg_valid), 32'h0);

        // Four back-to-back samples, then three spaced ones.
        for (int i = 0; i < 4; i++) applyStimulus(16'h0100);
        for (int i = 0; i < 3; i++) begin applyStimulus(16'h0100); tick(); end
        checkOutput("fill7_avg", 32'(avg_value), 32'h00E0);
        checkOutput("fill7_avgv", 32'(avg_valid), 32'h0);
        applyStimulus(16'h0100);
        checkOutput("fill8_avg", 32'(avg_value), 32'h0100);
        checkOutput("fill8_avgv", 32'(avg_valid), 32'h1);
        checkOutput("fill8_len", 32'(laser_enable), 32'h1);
        checkOutput("fill8_peak", 32'(peak_value), 32'h0100);
        tick();

        // Over-power trip after the third consecutive violation.
        applyStimulus(16'h0900); tick();
        applyStimulus(16'h0900);
        checkOutput("over2_fover", 32'(fault_over), 32'h0);
        checkOutput("over2_len", 32'(laser_enable), 32'h1);
        tick();
        applyStimulus(16'h0900);
        checkOutput("over3_fover", 32'(fault_over), 32'h1);
        checkOutput("over3_funder", 32'(fault_under), 32'h0);
        checkOutput("over3_len", 32'(laser_enable), 32'h0);
        checkOutput("over3_peak", 32'(peak_value), 32'h0900);
        tick();

        // Clear with no sample: back to IDLE, then a fresh FILL.
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        checkOutput("clr1_fover", 32'(fault_over), 32'h0);
        checkOutput("clr1_len", 32'(laser_enable), 32'h0);
        tick();
        checkOutput("clr1_refill_len", 32'(laser_enable), 32'h1);
        checkOutput("clr1_refill_avgv", 32'(avg_valid), 32'h0);
        checkOutput("clr1_refill_avg", 32'(avg_value), 32'h0);
        for (int i = 0; i < 8; i++) begin applyStimulus(16'h0100); tick(); end
        checkOutput("refill_avgv", 32'(avg_valid), 32'h1);

        // Interrupted violation run does not trip.
        applyStimulus(16'h0900); tick();
        applyStimulus(16'h0100); tick();
        applyStimulus(16'h0900); tick();
        applyStimulus(16'h0900);
        checkOutput("nodeb_fover", 32'(fault_over), 32'h0);
        checkOutput("nodeb_len", 32'(laser_enable), 32'h1);
        tick();

        // Under-power trip.
        applyStimulus(16'h0010); tick();
        applyStimulus(16'h0010); tick();
        applyStimulus(16'h0010);
        checkOutput("under_funder", 32'(fault_under), 32'h1);
        checkOutput("under_fover", 32'(fault_over), 32'h0);
        checkOutput("under_len", 32'(laser_enable), 32'h0);
        tick();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        checkOutput("clr2_funder", 32'(fault_under), 32'h0);
        checkOutput("clr2_len", 32'(laser_enable), 32'h0);
        tick();
        for (int i = 0; i < 7; i++) begin applyStimulus(16'h0100); tick(); end
        checkOutput("refill7_avgv", 32'(avg_valid), 32'h0);
        applyStimulus(16'h0100); tick();
        checkOutput("refill8_avgv", 32'(avg_valid), 32'h1);

        // Peak tracking and clears.
        clear_peak = 1'b1;
        tick();
        clear_peak = 1'b0;
        checkOutput("peak_clr", 32'(peak_value), 32'h0);
        applyStimulus(16'h0300); tick();
        applyStimulus(16'h0500); tick();
        applyStimulus(16'h0200);
        checkOutput("peak_max", 32'(peak_value), 32'h0500);
        tick();
        clear_peak = 1'b1;
        applyStimulus(16'h0123);
        clear_peak = 1'b0;
        checkOutput("peak_clr_smp", 32'(peak_value), 32'h0123);
        // window: 4 x 0x100, 0x300, 0x500, 0x200, 0x123 -> 0xF23 >> 3
        checkOutput("avg_mixed", 32'(avg_value), 32'h01E4);
        tick();

        // Sticky fault: monitor_en drop and a violating clear are ignored.
        for (int i = 0; i < 3; i++) begin applyStimulus(16'h0900); tick(); end
        checkOutput("sticky_fover", 32'(fault_over), 32'h1);
        monitor_en = 1'b0;
        tick(); tick();
        checkOutput("sticky_men_fover", 32'(fault_over), 32'h1);
        checkOutput("sticky_men_len", 32'(laser_enable), 32'h0);
        clear_fault = 1'b1;
        applyStimulus(16'h0900);
        clear_fault = 1'b0;
        checkOutput("sticky_clrbad_fover", 32'(fault_over), 32'h1);
        checkOutput("sticky_clrbad_len", 32'(laser_enable), 32'h0);
        tick();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        checkOutput("sticky_clr_fover", 32'(fault_over), 32'h0);
        tick();
        checkOutput("idle_len", 32'(laser_enable), 32'h0);

        // Reset in the middle of a fill.
        monitor_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin applyStimulus(16'h0200); tick(); end
        checkOutput("part_avg", 32'(avg_value), 32'h0140);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkReset("midrst");
        tick();
        checkOutput("midrst_fill_len", 32'(laser_enable), 32'h1);
        for (int i = 0; i < 7; i++) begin applyStimulus(16'h0200); tick(); end
        checkOutput("midrst7_avgv", 32'(avg_valid), 32'h0);
        checkOutput("midrst7_avg", 32'(avg_value), 32'h01C0);
        applyStimulus(16'h0200);
        checkOutput("midrst8_avgv", 32'(avg_valid), 32'h1);
        checkOutput("midrst8_avg", 32'(avg_value), 32'h0200);
        checkOutput("midrst8_peak", 32'(peak_value), 32'h0200);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
